// File: rtl/data_axi_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_axi_bridge : data-SRAM port to single-beat AXI master, stalls the pipe |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module data_axi_bridge #(
  parameter logic [3:0] AXI_ID  = 4'd1,
  parameter int         ADDR_WD = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_we,
  input  logic [1:0]         data_sram_size,
  input  logic [ADDR_WD-1:0] data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic               stallreq_axi,
  output logic [3:0]         arid,
  output logic [ADDR_WD-1:0] araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [3:0]         rid,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [3:0]         awid,
  output logic [ADDR_WD-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic               awvalid,
  input  logic               awready,
  output logic [3:0]         wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [3:0]         bid,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_WD-1:0] addr_reg, addr_nxt;
  logic [31:0]        wdata_reg, wdata_nxt;
  logic [3:0]         wstrb_reg, wstrb_nxt;
  logic [31:0]        rdata_reg, rdata_nxt;
  logic               arvalid_reg, arvalid_nxt;
  logic               awvalid_reg, awvalid_nxt;
  logic               wvalid_reg, wvalid_nxt;
  logic               rready_reg, rready_nxt;
  logic               bready_reg, bready_nxt;
  logic               aw_done, aw_done_nxt;
  logic               w_done, w_done_nxt;
  logic               aw_fire, w_fire;
  logic               unused_inputs;

  assign aw_fire = awvalid_reg & awready;
  assign w_fire  = wvalid_reg & wready;

  // Response IDs/status are not checked: only one transaction is ever outstanding.
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rdata_reg   <= '0;
      arvalid_reg <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      rready_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr_reg    <= addr_nxt;
      wdata_reg   <= wdata_nxt;
      wstrb_reg   <= wstrb_nxt;
      rdata_reg   <= rdata_nxt;
      arvalid_reg <= arvalid_nxt;
      awvalid_reg <= awvalid_nxt;
      wvalid_reg  <= wvalid_nxt;
      rready_reg  <= rready_nxt;
      bready_reg  <= bready_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_reg;
    wdata_nxt   = wdata_reg;
    wstrb_nxt   = wstrb_reg;
    rdata_nxt   = rdata_reg;
    arvalid_nxt = arvalid_reg;
    awvalid_nxt = awvalid_reg;
    wvalid_nxt  = wvalid_reg;
    rready_nxt  = rready_reg;
    bready_nxt  = bready_reg;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          addr_nxt = data_sram_addr;
          if (data_sram_we == 4'b0000) begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_AR;
          end else begin
            wdata_nxt   = data_sram_wdata;
            wstrb_nxt   = data_sram_we;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_AWW;
          end
        end
      end
      RD_AR: begin
        if (arvalid_reg && arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end
      RD_R: begin
        if (rvalid && rready_reg) begin
          rdata_nxt  = rdata;
          rready_nxt = 1'b0;
          state_nxt  = DONE;
        end
      end
      WR_AWW: begin
        if (aw_fire) awvalid_nxt = 1'b0;
        if (w_fire)  wvalid_nxt  = 1'b0;
        // Either channel may finish first; both may also finish in the same cycle.
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          bready_nxt  = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = WR_B;
        end else begin
          aw_done_nxt = aw_done | aw_fire;
          w_done_nxt  = w_done | w_fire;
        end
      end
      WR_B: begin
        if (bvalid && bready_reg) begin
          bready_nxt = 1'b0;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stallreq_axi    = ((state == IDLE) && data_sram_en) ||
                           ((state != IDLE) && (state != DONE));
  assign data_sram_rdata = rdata_reg;

  assign arid    = AXI_ID;
  assign araddr  = addr_reg;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, data_sram_size};
  assign arburst = 2'b01;
  assign arvalid = arvalid_reg;
  assign rready  = rready_reg;

  assign awid    = AXI_ID;
  assign awaddr  = addr_reg;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, data_sram_size};
  assign awburst = 2'b01;
  assign awvalid = awvalid_reg;

  assign wid     = AXI_ID;
  assign wdata   = wdata_reg;
  assign wstrb   = wstrb_reg;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_reg;
  assign bready  = bready_reg;

endmodule
`default_nettype wire

// File: doc/data_axi_bridge.md
Name: data_axi_bridge

Overview:
- Data-side bridge between the CPU's data-SRAM-style port and a single-beat AXI3/AXI4 master interface.
- It completes the other end of the path that the memory stage consumes: it accepts load/store requests and issues AXI read or write bursts of length 1.
- It drives `data_sram_rdata` back to the memory stage.
- It raises `stallreq_axi` to freeze the pipeline until the transaction completes.

Parameters:
- AXI_ID, 4'd1, fixed ID driven on arid/awid/wid.
- ADDR_WD, 32, address width (both sides).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- data_sram_en  in  1  request valid, held stable by the pipeline while stalled
- data_sram_we  in  4  byte write enables; 0 = load, nonzero = store
- data_sram_size  in  2  0=byte, 1=half, 2=word
- data_sram_addr  in  ADDR_WD  byte address
- data_sram_wdata  in  32  store data, already lane-aligned
- data_sram_rdata  out  32  load data, registered
- stallreq_axi  out  1  pipeline stall request
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/ADDR_WD/8/3/2/1  AXI read address
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1
- rready  out  1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/ADDR_WD/8/3/2/1
- awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1
- wready  in  1
- bid/bresp/bvalid  in  4/2/1
- bready  out  1

Behaviour:
- **Reset** (reset==0 at posedge): state=IDLE; arvalid, awvalid, wvalid, rready, bready = 0; data_sram_rdata=0; aw_done=w_done=0. A reset mid-transaction abandons it; only whole-system reset is used.
- **Constant fields:** arlen=awlen=0; arburst=awburst=2'b01; wlast=1; IDs=AXI_ID; arsize=awsize={1'b0,data_sram_size}. Address, data and strobe registers are captured at acceptance and held until the handshake.
- **States:** IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
- **IDLE:** if data_sram_en:
  - we==0: capture araddr, set arvalid=1, go to RD_AR.
  - else: capture awaddr, wdata and wstrb=we, set awvalid=wvalid=1, go to WR_AWW.
- **RD_AR:** on arvalid&arready, clear arvalid, set rready=1, go to RD_R.
- **RD_R:** on rvalid&rready, latch data_sram_rdata<=rdata, clear rready, go to DONE. rresp is ignored.
- **WR_AWW:** the AW and W handshakes are tracked independently.
  - awvalid&awready clears awvalid and sets aw_done; wvalid&wready clears wvalid and sets w_done.
  - When both are complete (including both handshakes in the same cycle), set bready=1, clear the done flags and go to WR_B.
  - W may complete before AW.
- **WR_B:** on bvalid&bready, clear bready, go to DONE. bresp is ignored.
- **DONE:** lasts one cycle, then IDLE. data_sram_rdata holds its value until the next read's R handshake.
- **stallreq_axi** (combinational) = (state==IDLE & data_sram_en) | (state!=IDLE & state!=DONE). It is therefore 0 in DONE, and the pipeline advances exactly then.
- **Latency:** minimum read is 4 cycles from en to the DONE cycle (IDLE→AR→R→DONE) with zero-wait slaves. A write has the same minimum.
- A request present in DONE is not accepted; it is re-evaluated in IDLE the next cycle.
- Only one transaction is outstanding; there is no pipelining of requests.

Test Plan:
- **Load, zero-wait:** en=1, we=0, size=2, addr=0x1C00_0010; slave returns arready on the first cycle and rdata=0xDEAD_BEEF next → arvalid for 1 cycle with araddr=0x1C00_0010 and arsize=2; stallreq_axi=1 for 3 cycles, then 0; data_sram_rdata=0xDEAD_BEEF in DONE and held afterwards.
- **Store byte:** we=4'b0100, size=0, addr=0x…02, wdata=0x00AB_0000 → awsize=0, wstrb=4'b0100, wlast=1; bready rises after both handshakes; stall drops on the cycle after bvalid.
- **W before AW:** wready=1 immediately, awready delayed 3 cycles → wvalid drops after 1 cycle, awvalid stays asserted 4 cycles, then WR_B; no duplicate W beat.
- **Read backpressure:** arready delayed 5 cycles and rvalid delayed 4 → stallreq_axi stays continuously 1; rdata latched only on rvalid&rready.
- **Back-to-back:** load then store with en held → exactly one transaction each; a one-cycle DONE gap appears between them; the load data is unchanged by the store.
- **Mid-transaction reset:** reset=0 while in RD_R → next cycle state=IDLE, all valid/ready=0, data_sram_rdata=0, stallreq_axi=0 (when en=0).
